// File: rtl/kf8255_pkg.sv
// -----------------------------------------------------------------------------
// kf8255_pkg
// Shared definitions for the 8255-style mode-1 handshake controller:
//   - group mode encodings (MODE_0 / MODE_1 / MODE_2)
//   - port direction encodings (PORT_INPUT / PORT_OUTPUT)
//   - handshake FSM state enum
// -----------------------------------------------------------------------------
package kf8255_pkg;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;

    localparam logic PORT_INPUT  = 1'b1;
    localparam logic PORT_OUTPUT = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IN_STROBE = 3'd1,
        IN_FULL   = 3'd2,
        OUT_FULL  = 3'd3,
        OUT_ACK   = 3'd4
    } hs_state_t;

endpackage

// File: rtl/kf8255_edge_sync.sv
// -----------------------------------------------------------------------------
// kf8255_edge_sync
// Samples an asynchronous active-low handshake pin and produces one-cycle
// rise/fall pulses. All flops update on the falling clock edge and reset to 1
// (pin idle level), so no spurious edge appears when reset is released.
//
// Configuration macro: KF8255_HANDSHAKE_SYNC_EN
//   defined   : 2-flop synchronizer, flag response on the 3rd falling edge
//   undefined : single sampling flop, flag response on the 2nd falling edge
//
// Ports:
//   clock  in  system clock (falling edge active)
//   reset  in  asynchronous, active-high reset
//   pin_n  in  asynchronous active-low pin (STB# or ACK#)
//   rise   out one-cycle pulse on a low-to-high transition of the pin
//   fall   out one-cycle pulse on a high-to-low transition of the pin
// -----------------------------------------------------------------------------
module kf8255_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin_n,
    output logic rise,
    output logic fall
);

    logic sampled;
    logic prev;

`ifdef KF8255_HANDSHAKE_SYNC_EN
    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            meta    <= 1'b1;
            sampled <= 1'b1;
        end else begin
            meta    <= pin_n;
            sampled <= meta;
        end
    end
`else
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sampled <= 1'b1;
        end else begin
            sampled <= pin_n;
        end
    end
`endif

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= sampled;
        end
    end

    assign fall = prev & ~sampled;
    assign rise = ~prev & sampled;

endmodule

// File: rtl/kf8255_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// kf8255_handshake_ctrl
// Mode-1 strobed I/O handshake for one 8255 port group. In input mode STB#
// latches pin data and raises IBF; a CPU read empties the buffer. In output
// mode a CPU write loads the output latch and drops OBF#; ACK# from the
// peripheral completes the transfer. INTR follows INTE at the end of each
// transfer. Handshaking is only active in group mode 1.
//
// Configuration macro: KF8255_HANDSHAKE_SYNC_EN (see kf8255_edge_sync).
//
// Ports:
//   clock              in   system clock, all state on its falling edge
//   reset              in   asynchronous, active-high reset
//   mode_select_reg    in   group mode (only MODE_1 handshakes)
//   port_io_reg        in   port direction, 1 = input, 0 = output
//   update_group_mode  in   pulse: mode rewrite, clears all handshake state
//   inte_write         in   pulse: load inte from inte_value
//   inte_value         in   value loaded into inte
//   read_port          in   pulse: CPU read of the port
//   write_port         in   pulse: CPU write of the port
//   cpu_data[7:0]      in   CPU write data
//   port_data_in[7:0]  in   external pin data
//   strobe_n           in   STB#, asynchronous, active-low
//   ack_n              in   ACK#, asynchronous, active-low
//   port_data_latched  out  input latch toward CPU / output latch toward pins
//   ibf                out  input buffer full
//   obf_n              out  output buffer full, active-low
//   intr               out  interrupt request
//   inte               out  interrupt enable
// -----------------------------------------------------------------------------
module kf8255_handshake_ctrl
    import kf8255_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_select_reg,
    input  logic       port_io_reg,
    input  logic       update_group_mode,
    input  logic       inte_write,
    input  logic       inte_value,
    input  logic       read_port,
    input  logic       write_port,
    input  logic [7:0] cpu_data,
    input  logic [7:0] port_data_in,
    input  logic       strobe_n,
    input  logic       ack_n,
    output logic [7:0] port_data_latched,
    output logic       ibf,
    output logic       obf_n,
    output logic       intr,
    output logic       inte
);

    hs_state_t  state, state_nxt;
    logic [7:0] latched_nxt;
    logic       ibf_nxt, obf_n_nxt, intr_nxt, inte_nxt;
    logic       port_io_q;

    logic stb_rise, stb_fall;
    logic ack_rise, ack_fall;

    kf8255_edge_sync u_stb_sync (
        .clock (clock),
        .reset (reset),
        .pin_n (strobe_n),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    kf8255_edge_sync u_ack_sync (
        .clock (clock),
        .reset (reset),
        .pin_n (ack_n),
        .rise  (ack_rise),
        .fall  (ack_fall)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            port_data_latched <= 8'h00;
            ibf               <= 1'b0;
            obf_n             <= 1'b1;
            intr              <= 1'b0;
            inte              <= 1'b0;
            port_io_q         <= PORT_INPUT;
        end else begin
            state             <= state_nxt;
            port_data_latched <= latched_nxt;
            ibf               <= ibf_nxt;
            obf_n             <= obf_n_nxt;
            intr              <= intr_nxt;
            inte              <= inte_nxt;
            port_io_q         <= port_io_reg;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first; any path that
        // skipped an assignment would otherwise infer a latch.
        state_nxt   = state;
        latched_nxt = port_data_latched;
        ibf_nxt     = ibf;
        obf_n_nxt   = obf_n;
        intr_nxt    = intr;
        inte_nxt    = inte;

        if (update_group_mode) begin
            state_nxt = IDLE;
            ibf_nxt   = 1'b0;
            obf_n_nxt = 1'b1;
            intr_nxt  = 1'b0;
            inte_nxt  = 1'b0;
        end else begin
            if (inte_write) begin
                inte_nxt = inte_value;
            end

            if (mode_select_reg != MODE_1 || port_io_reg != port_io_q) begin
                // Handshake disabled, or direction flipped under us: abandon
                // any transfer and park the flags at their inactive levels.
                state_nxt = IDLE;
                ibf_nxt   = 1'b0;
                obf_n_nxt = 1'b1;
                intr_nxt  = 1'b0;
            end else if (port_io_reg == PORT_INPUT) begin
                // A strobe fall beats a coincident read: the new byte must not
                // be lost, so the buffer stays full.
                if (stb_fall && (state == IDLE || state == IN_FULL)) begin
                    latched_nxt = port_data_in;
                    ibf_nxt     = 1'b1;
                    intr_nxt    = 1'b0;
                    state_nxt   = IN_STROBE;
                end else if (stb_rise && state == IN_STROBE) begin
                    intr_nxt  = inte;
                    state_nxt = IN_FULL;
                end else if (read_port) begin
                    intr_nxt = 1'b0;
                    if (state == IN_FULL) begin
                        ibf_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end else begin
                // A write discards any ACK# edge arriving on the same cycle.
                if (write_port) begin
                    latched_nxt = cpu_data;
                    obf_n_nxt   = 1'b0;
                    intr_nxt    = 1'b0;
                    state_nxt   = OUT_FULL;
                end else if (ack_fall && state == OUT_FULL) begin
                    obf_n_nxt = 1'b1;
                    state_nxt = OUT_ACK;
                end else if (ack_rise && state == OUT_ACK) begin
                    intr_nxt  = inte;
                    state_nxt = IDLE;
                end
            end

            // Disabling interrupts withdraws a pending request immediately.
            if (inte_write && !inte_value) begin
                intr_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kf8255_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kf8255_handshake_ctrl
// Directed bench for kf8255_handshake_ctrl. Inputs change 1 time unit after a
// falling clock edge and outputs are checked at the same point, i.e. they show
// the result of the preceding falling edge. Pin-to-flag latency is 3 edges
// with KF8255_HANDSHAKE_SYNC_EN defined, 2 otherwise.
// -----------------------------------------------------------------------------
module tb_kf8255_handshake_ctrl;

`ifdef KF8255_HANDSHAKE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clock;
    logic       reset;
    logic [1:0] mode_select_reg;
    logic       port_io_reg;
    logic       update_group_mode;
    logic       inte_write;
    logic       inte_value;
    logic       read_port;
    logic       write_port;
    logic [7:0] cpu_data;
    logic [7:0] port_data_in;
    logic       strobe_n;
    logic       ack_n;
    logic [7:0] port_data_latched;
    logic       ibf;
    logic       obf_n;
    logic       intr;
    logic       inte;

    int tests_run;
    int tests_failed;

    kf8255_handshake_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .mode_select_reg   (mode_select_reg),
        .port_io_reg       (port_io_reg),
        .update_group_mode (update_group_mode),
        .inte_write        (inte_write),
        .inte_value        (inte_value),
        .read_port         (read_port),
        .write_port        (write_port),
        .cpu_data          (cpu_data),
        .port_data_in      (port_data_in),
        .strobe_n          (strobe_n),
        .ack_n             (ack_n),
        .port_data_latched (port_data_latched),
        .ibf               (ibf),
        .obf_n             (obf_n),
        .intr              (intr),
        .inte              (inte)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic load_inte(input logic v);
        inte_write = 1'b1;
        inte_value = v;
        step(1);
        inte_write = 1'b0;
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        mode_select_reg   = 2'b01;
        port_io_reg       = 1'b1;
        update_group_mode = 1'b0;
        inte_write        = 1'b0;
        inte_value        = 1'b0;
        read_port         = 1'b0;
        write_port        = 1'b0;
        cpu_data          = 8'h00;
        port_data_in      = 8'h00;
        strobe_n          = 1'b1;
        ack_n             = 1'b1;

        // Reset state
        #22;
        check("rst_ibf", ibf, 1'b0);
        check("rst_obf_n", obf_n, 1'b1);
        check("rst_intr", intr, 1'b0);
        check("rst_inte", inte, 1'b0);
        check("rst_latched", port_data_latched, 8'h00);
        reset = 1'b0;
        step(2);

        // Input handshake with inte = 1, pin 5Ah
        load_inte(1'b1);
        check("in_inte_set", inte, 1'b1);
        port_data_in = 8'h5A;
        strobe_n     = 1'b0;
        step(LAT - 1);
        check("in_ibf_before_latency", ibf, 1'b0);
        step(1);
        check("in_ibf_at_latency", ibf, 1'b1);
        check("in_latched_5a", port_data_latched, 8'h5A);
        check("in_intr_low_strobe", intr, 1'b0);
        step(4 - LAT);
        strobe_n = 1'b1;
        step(LAT - 1);
        check("in_intr_before_rise", intr, 1'b0);
        step(1);
        check("in_intr_after_rise", intr, 1'b1);
        check("in_ibf_held", ibf, 1'b1);
        read_port = 1'b1;
        step(1);
        read_port = 1'b0;
        check("in_read_ibf", ibf, 1'b0);
        check("in_read_intr", intr, 1'b0);

        // Fill buffer again (11h), then read coincident with a new strobe (33h)
        port_data_in = 8'h11;
        strobe_n     = 1'b0;
        step(LAT + 1);
        strobe_n = 1'b1;
        step(LAT + 1);
        check("full2_intr", intr, 1'b1);
        port_data_in = 8'h33;
        strobe_n     = 1'b0;
        step(LAT - 1);
        read_port = 1'b1;
        step(1);
        read_port = 1'b0;
        check("race_ibf", ibf, 1'b1);
        check("race_latched_33", port_data_latched, 8'h33);
        check("race_intr", intr, 1'b0);
        strobe_n = 1'b1;
        step(LAT);
        check("race_intr_after_rise", intr, 1'b1);

        // Clearing inte withdraws intr on the same edge
        load_inte(1'b0);
        check("inte_clr_intr", intr, 1'b0);
        check("inte_clr_inte", inte, 1'b0);
        // Re-enabling must not resurrect the request
        load_inte(1'b1);
        check("inte_set_no_retro", intr, 1'b0);
        read_port = 1'b1;
        step(1);
        read_port = 1'b0;
        check("drain_ibf", ibf, 1'b0);

        // Output handshake, A5h
        port_io_reg = 1'b0;
        step(2);
        check("out_dir_ibf", ibf, 1'b0);
        cpu_data   = 8'hA5;
        write_port = 1'b1;
        step(1);
        write_port = 1'b0;
        check("out_obf_n_low", obf_n, 1'b0);
        check("out_latched_a5", port_data_latched, 8'hA5);
        // STB# in output mode is ignored
        strobe_n = 1'b0;
        step(LAT + 1);
        strobe_n = 1'b1;
        check("out_stb_ignored", port_data_latched, 8'hA5);
        ack_n = 1'b0;
        step(LAT - 1);
        check("out_obf_n_before_ack", obf_n, 1'b0);
        step(1);
        check("out_obf_n_ack", obf_n, 1'b1);
        ack_n = 1'b1;
        step(LAT - 1);
        check("out_intr_before_rise", intr, 1'b0);
        step(1);
        check("out_intr_after_rise", intr, 1'b1);

        // write_port coincident with ACK# fall: write wins, ACK discarded
        cpu_data   = 8'hC3;
        write_port = 1'b1;
        step(1);
        write_port = 1'b0;
        check("wr2_intr_clr", intr, 1'b0);
        ack_n = 1'b0;
        step(LAT - 1);
        cpu_data   = 8'h3C;
        write_port = 1'b1;
        step(1);
        write_port = 1'b0;
        check("wr_ack_race_obf_n", obf_n, 1'b0);
        check("wr_ack_race_latched", port_data_latched, 8'h3C);
        ack_n = 1'b1;
        step(LAT + 1);
        check("wr_ack_race_rise_ignored", obf_n, 1'b0);
        check("wr_ack_race_intr", intr, 1'b0);

        // update_group_mode in OUT_FULL
        update_group_mode = 1'b1;
        step(1);
        update_group_mode = 1'b0;
        check("ugm_obf_n", obf_n, 1'b1);
        check("ugm_inte", inte, 1'b0);
        check("ugm_intr", intr, 1'b0);
        // In IDLE an ACK# pulse does nothing, even with inte re-enabled
        load_inte(1'b1);
        ack_n = 1'b0;
        step(LAT + 1);
        ack_n = 1'b1;
        step(LAT + 1);
        check("idle_ack_obf_n", obf_n, 1'b1);
        check("idle_ack_intr", intr, 1'b0);

        // Mode 0: strobes have no effect
        port_io_reg     = 1'b1;
        mode_select_reg = 2'b00;
        step(2);
        port_data_in = 8'h77;
        strobe_n     = 1'b0;
        step(LAT + 1);
        strobe_n = 1'b1;
        step(LAT + 1);
        check("m0_ibf", ibf, 1'b0);
        check("m0_intr", intr, 1'b0);
        check("m0_latched", port_data_latched, 8'h3C);

        // Reset during IN_STROBE
        mode_select_reg = 2'b01;
        step(2);
        port_data_in = 8'h99;
        strobe_n     = 1'b0;
        step(LAT + 1);
        check("pre_rst_ibf", ibf, 1'b1);
        check("pre_rst_latched", port_data_latched, 8'h99);
        reset = 1'b1;
        #1;
        check("mid_rst_ibf", ibf, 1'b0);
        check("mid_rst_obf_n", obf_n, 1'b1);
        check("mid_rst_intr", intr, 1'b0);
        check("mid_rst_inte", inte, 1'b0);
        check("mid_rst_latched", port_data_latched, 8'h00);
        strobe_n = 1'b1;
        step(2);
        reset = 1'b0;
        step(LAT + 2);
        check("post_rst_ibf", ibf, 1'b0);
        check("post_rst_intr", intr, 1'b0);
        check("post_rst_latched", port_data_latched, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
